// File: rtl/vrf_rd_port_scheduler.sv
// Requester-side scheduler for the two VRF read ports: collects single-outstanding
// requests, drives the external two-grant arbiter, issues reads and routes data back.
module vrf_rd_port_scheduler #(
  parameter int NUM_SRC    = 8,
  parameter int IDX_WIDTH  = 3,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_req_valid,
  input  logic [NUM_SRC*ADDR_WIDTH-1:0] src_req_addr,
  output logic [NUM_SRC-1:0]            src_req_ready,
  output logic [NUM_SRC-1:0]            rsp_valid,
  output logic [NUM_SRC*DATA_WIDTH-1:0] rsp_data,
  output logic [NUM_SRC-1:0]            arb_req,
  output logic [IDX_WIDTH-1:0]          arb_priority_idx,
  input  logic [NUM_SRC-1:0]            arb_gnt_first,
  input  logic [NUM_SRC-1:0]            arb_gnt_second,
  output logic                          rf_rd0_en,
  output logic [ADDR_WIDTH-1:0]         rf_rd0_addr,
  input  logic [DATA_WIDTH-1:0]         rf_rd0_data,
  output logic                          rf_rd1_en,
  output logic [ADDR_WIDTH-1:0]         rf_rd1_addr,
  input  logic [DATA_WIDTH-1:0]         rf_rd1_data
);

  logic [NUM_SRC-1:0]            r_busy;
  logic [NUM_SRC-1:0]            r_pending;
  logic [ADDR_WIDTH-1:0]         r_addr_q [NUM_SRC];
  logic [IDX_WIDTH-1:0]          r_ptr;
  logic                          r_rd0_v, r_rd1_v;
  logic [IDX_WIDTH-1:0]          r_rd0_src, r_rd1_src;
  logic [ADDR_WIDTH-1:0]         r_rd0_addr, r_rd1_addr;
  logic                          r_s2_0_v, r_s2_1_v;
  logic [IDX_WIDTH-1:0]          r_s2_0_src, r_s2_1_src;
  logic [NUM_SRC-1:0]            r_rsp_valid;
  logic [NUM_SRC*DATA_WIDTH-1:0] r_rsp_data;

  logic [NUM_SRC-1:0]    w_accept;
  logic [NUM_SRC-1:0]    w_g0, w_g1;
  logic [IDX_WIDTH-1:0]  w_g0_idx, w_g1_idx;
  logic [ADDR_WIDTH-1:0] w_g0_addr, w_g1_addr;
  logic [NUM_SRC-1:0]    w_rsp_set;

  assign w_accept = src_req_valid & ~r_busy;

  // Grants are masked with pending so stray arbiter bits cannot issue reads.
  always_comb begin
    w_g0      = arb_gnt_first & r_pending;
    w_g1      = arb_gnt_second & r_pending & ~w_g0;
    w_g0_idx  = '0;
    w_g1_idx  = '0;
    w_g0_addr = '0;
    w_g1_addr = '0;
    w_rsp_set = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (w_g0[i]) begin
        w_g0_idx  = IDX_WIDTH'(i);
        w_g0_addr = w_g0_addr | r_addr_q[i];
      end
      if (w_g1[i]) begin
        w_g1_idx  = IDX_WIDTH'(i);
        w_g1_addr = w_g1_addr | r_addr_q[i];
      end
      if ((r_s2_0_v && r_s2_0_src == IDX_WIDTH'(i)) ||
          (r_s2_1_v && r_s2_1_src == IDX_WIDTH'(i)))
        w_rsp_set[i] = 1'b1;
    end
  end

  // busy drops on the edge after the response strobe, so ready returns one
  // cycle after rsp_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy    <= '0;
      r_pending <= '0;
      r_ptr     <= '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) r_addr_q[i] <= '0;
    end else begin
      r_busy    <= (r_busy | w_accept) & ~r_rsp_valid;
      r_pending <= (r_pending | w_accept) & ~(w_g0 | w_g1);
      for (int unsigned i = 0; i < NUM_SRC; i++)
        if (w_accept[i]) r_addr_q[i] <= src_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (|w_g1)      r_ptr <= w_g1_idx + IDX_WIDTH'(1);
      else if (|w_g0) r_ptr <= w_g0_idx + IDX_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd0_v    <= 1'b0;
      r_rd1_v    <= 1'b0;
      r_rd0_src  <= '0;
      r_rd1_src  <= '0;
      r_rd0_addr <= '0;
      r_rd1_addr <= '0;
      r_s2_0_v   <= 1'b0;
      r_s2_1_v   <= 1'b0;
      r_s2_0_src <= '0;
      r_s2_1_src <= '0;
    end else begin
      r_rd0_v    <= |w_g0;
      r_rd1_v    <= |w_g1;
      if (|w_g0) begin
        r_rd0_src  <= w_g0_idx;
        r_rd0_addr <= w_g0_addr;
      end
      if (|w_g1) begin
        r_rd1_src  <= w_g1_idx;
        r_rd1_addr <= w_g1_addr;
      end
      r_s2_0_v   <= r_rd0_v;
      r_s2_1_v   <= r_rd1_v;
      r_s2_0_src <= r_rd0_src;
      r_s2_1_src <= r_rd1_src;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_rsp_set;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (r_s2_0_v && r_s2_0_src == IDX_WIDTH'(i))
          r_rsp_data[i*DATA_WIDTH +: DATA_WIDTH] <= rf_rd0_data;
        if (r_s2_1_v && r_s2_1_src == IDX_WIDTH'(i))
          r_rsp_data[i*DATA_WIDTH +: DATA_WIDTH] <= rf_rd1_data;
      end
    end
  end

  assign src_req_ready    = ~r_busy;
  assign rsp_valid        = r_rsp_valid;
  assign rsp_data         = r_rsp_data;
  assign arb_req          = r_pending;
  assign arb_priority_idx = r_ptr;
  assign rf_rd0_en        = r_rd0_v;
  assign rf_rd0_addr      = r_rd0_addr;
  assign rf_rd1_en        = r_rd1_v;
  assign rf_rd1_addr      = r_rd1_addr;

  a_g0_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(w_g0));
  a_g1_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(w_g1));

endmodule

// File: tb/tb_vrf_rd_port_scheduler.sv
// Scoreboard bench: rotating two-grant arbiter and register file modelled here,
// expected read data queued per source and checked when rsp_valid strobes.
`timescale 1ns/1ps
module tb_vrf_rd_port_scheduler;
  localparam int N  = 8;
  localparam int IW = 3;
  localparam int AW = 5;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    src_req_valid;
  logic [N*AW-1:0] src_req_addr;
  logic [N-1:0]    src_req_ready;
  logic [N-1:0]    rsp_valid;
  logic [N*DW-1:0] rsp_data;
  logic [N-1:0]    arb_req;
  logic [IW-1:0]   arb_priority_idx;
  logic [N-1:0]    arb_gnt_first, arb_gnt_second;
  logic            rf_rd0_en, rf_rd1_en;
  logic [AW-1:0]   rf_rd0_addr, rf_rd1_addr;
  logic [DW-1:0]   rf_rd0_data, rf_rd1_data;

  vrf_rd_port_scheduler #(.NUM_SRC(N), .IDX_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .src_req_valid(src_req_valid), .src_req_addr(src_req_addr), .src_req_ready(src_req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .arb_req(arb_req), .arb_priority_idx(arb_priority_idx),
    .arb_gnt_first(arb_gnt_first), .arb_gnt_second(arb_gnt_second),
    .rf_rd0_en(rf_rd0_en), .rf_rd0_addr(rf_rd0_addr), .rf_rd0_data(rf_rd0_data),
    .rf_rd1_en(rf_rd1_en), .rf_rd1_addr(rf_rd1_addr), .rf_rd1_data(rf_rd1_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem [32];
  logic          arb_mode = 1'b0;
  logic [N-1:0]  arb_force = '0;
  logic          lat_chk = 1'b1;

  // Rotating-priority arbiter: first two pending sources from the pointer onward.
  always_comb begin : arb_model
    int found;
    int k;
    found = 0;
    k = 0;
    arb_gnt_first  = '0;
    arb_gnt_second = '0;
    for (int j = 0; j < N; j++) begin
      k = (int'(arb_priority_idx) + j) % N;
      if (arb_req[k]) begin
        if (found == 0)      arb_gnt_first[k]  = 1'b1;
        else if (found == 1) arb_gnt_second[k] = 1'b1;
        found++;
      end
    end
    if (arb_mode) begin
      arb_gnt_first  = arb_force;
      arb_gnt_second = '0;
    end
  end

  always @(posedge clk) begin
    if (rf_rd0_en) rf_rd0_data <= mem[rf_rd0_addr];
    if (rf_rd1_en) rf_rd1_data <= mem[rf_rd1_addr];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Reference model of per-source state, pointer and expected responses.
  logic [N-1:0]  busy_m = '0;
  logic [N-1:0]  pend_m = '0;
  int            ptr_m = 0;
  int            acc_cyc [N];
  logic [DW-1:0] exq [N][$];

  always @(negedge clk) begin : monitor
    logic [N-1:0]  busy_now, rdy_exp, g0, g1;
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    int            lat;
    if (rst) begin
      busy_m = '0;
      pend_m = '0;
      ptr_m  = 0;
      for (int i = 0; i < N; i++) exq[i].delete();
      chk("rsp_valid_in_reset", {56'b0, rsp_valid}, 64'd0);
    end else begin
      busy_now = busy_m;
      rdy_exp  = ~busy_now;
      chk("src_req_ready", {56'b0, src_req_ready}, {56'b0, rdy_exp});
      chk("arb_req", {56'b0, arb_req}, {56'b0, pend_m});
      chk("arb_priority_idx", {61'b0, arb_priority_idx}, 64'(ptr_m));
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i]) begin
          if (exq[i].size() == 0) begin
            chk("rsp_unexpected", {56'b0, rsp_valid}, {56'b0, rsp_valid & ~(8'd1 << i)});
          end else begin
            d = exq[i].pop_front();
            chk("rsp_data", rsp_data[i*DW +: DW], d);
            if (lat_chk) begin
              lat = cyc - acc_cyc[i];
              checks++;
              if (lat < 4 || lat > 4 + N/2 - 1) begin
                failures++;
                $display("FAIL rsp_latency src %0d: got %0d expected 4..%0d", i, lat, 4 + N/2 - 1);
              end
            end
          end
          busy_m[i] = 1'b0;
        end
      end
      g0 = arb_gnt_first & pend_m;
      g1 = arb_gnt_second & pend_m & ~g0;
      pend_m = pend_m & ~(g0 | g1);
      if (g1 != 0)      ptr_m = (idx_of(g1) + 1) % N;
      else if (g0 != 0) ptr_m = (idx_of(g0) + 1) % N;
      for (int i = 0; i < N; i++) begin
        if (src_req_valid[i] && !busy_now[i]) begin
          a = src_req_addr[i*AW +: AW];
          busy_m[i] = 1'b1;
          pend_m[i] = 1'b1;
          exq[i].push_back(mem[a]);
          acc_cyc[i] = cyc;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_req_valid = '0;
    arb_mode = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    src_req_valid = '0;
    repeat (n) tick();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    src_req_valid = '0;
    src_req_addr  = '0;
    for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom};
    mem[9] = 64'hABCD;
    do_reset();

    // Single request, src 3 addr 9
    src_req_valid = 8'h08;
    src_req_addr[3*AW +: AW] = 5'd9;
    @(negedge clk);
    chk("t1_ready_c0", {63'b0, src_req_ready[3]}, 64'd1);
    tick();
    src_req_valid = '0;
    @(negedge clk);
    chk("t1_arb_req_c1", {56'b0, arb_req}, 64'h08);
    @(negedge clk);
    chk("t1_en0_c2", {63'b0, rf_rd0_en}, 64'd1);
    chk("t1_addr0_c2", {59'b0, rf_rd0_addr}, 64'd9);
    chk("t1_en1_c2", {63'b0, rf_rd1_en}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    chk("t1_rsp_valid_c4", {56'b0, rsp_valid}, 64'h08);
    chk("t1_rsp_data_c4", rsp_data[3*DW +: DW], 64'hABCD);
    @(negedge clk);
    chk("t1_ready_c5", {63'b0, src_req_ready[3]}, 64'd1);
    tick();

    // Dual grant, srcs 1 and 6 from pointer 0
    do_reset();
    src_req_valid = 8'h42;
    src_req_addr[1*AW +: AW] = 5'd4;
    src_req_addr[6*AW +: AW] = 5'd17;
    tick();
    src_req_valid = '0;
    @(negedge clk);
    chk("t2_arb_req", {56'b0, arb_req}, 64'h42);
    @(negedge clk);
    chk("t2_en_both", {62'b0, rf_rd1_en, rf_rd0_en}, 64'd3);
    chk("t2_addr0", {59'b0, rf_rd0_addr}, 64'd4);
    chk("t2_addr1", {59'b0, rf_rd1_addr}, 64'd17);
    chk("t2_ptr", {61'b0, arb_priority_idx}, 64'd7);
    @(negedge clk);
    @(negedge clk);
    chk("t2_rsp_both", {56'b0, rsp_valid}, 64'h42);
    tick();
    drain(3);

    // Fairness, all sources from pointer 0
    do_reset();
    src_req_valid = 8'hFF;
    for (int i = 0; i < N; i++) src_req_addr[i*AW +: AW] = AW'(i + 10);
    tick();
    src_req_valid = '0;
    @(negedge clk);
    chk("t3_arb_req", {56'b0, arb_req}, 64'hFF);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_ptr", {61'b0, arb_priority_idx}, 64'((2*k + 2) % N));
      chk("t3_addr0", {59'b0, rf_rd0_addr}, 64'(10 + 2*k));
      chk("t3_addr1", {59'b0, rf_rd1_addr}, 64'(11 + 2*k));
    end
    tick();
    drain(8);

    // Wrap: pointer 6, srcs 7 and 0 pending
    do_reset();
    src_req_valid = 8'h20;
    src_req_addr[5*AW +: AW] = 5'd3;
    tick();
    drain(7);
    @(negedge clk);
    chk("t4_ptr_pre", {61'b0, arb_priority_idx}, 64'd6);
    tick();
    src_req_valid = 8'h81;
    src_req_addr[7*AW +: AW] = 5'd20;
    src_req_addr[0*AW +: AW] = 5'd21;
    tick();
    src_req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("t4_addr0", {59'b0, rf_rd0_addr}, 64'd20);
    chk("t4_addr1", {59'b0, rf_rd1_addr}, 64'd21);
    chk("t4_ptr", {61'b0, arb_priority_idx}, 64'd1);
    tick();
    drain(6);

    // Illegal grant bit outside pending
    do_reset();
    lat_chk = 1'b0;
    arb_mode = 1'b1;
    arb_force = 8'h10;
    src_req_valid = 8'h01;
    src_req_addr[0*AW +: AW] = 5'd2;
    tick();
    src_req_valid = '0;
    repeat (3) begin
      @(negedge clk);
      chk("t5_arb_req", {56'b0, arb_req}, 64'h01);
      chk("t5_ptr", {61'b0, arb_priority_idx}, 64'd0);
      chk("t5_no_issue", {62'b0, rf_rd1_en, rf_rd0_en}, 64'd0);
    end
    tick();
    arb_mode = 1'b0;
    drain(8);
    lat_chk = 1'b1;

    // Reset while a read is in flight
    do_reset();
    src_req_valid = 8'h04;
    src_req_addr[2*AW +: AW] = 5'd11;
    tick();
    src_req_valid = '0;
    begin : wait_en
      int n;
      n = 0;
      @(negedge clk);
      while (!rf_rd0_en && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("t6_en_seen", {63'b0, rf_rd0_en}, 64'd1);
    end
    tick();
    rst = 1'b1;
    #1;
    chk("t6_en_async_clear", {62'b0, rf_rd1_en, rf_rd0_en}, 64'd0);
    tick();
    tick();
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("t6_rsp_none", {56'b0, rsp_valid}, 64'd0);
      chk("t6_ready", {56'b0, src_req_ready}, 64'hFF);
      chk("t6_ptr", {61'b0, arb_priority_idx}, 64'd0);
    end
    tick();

    // Randomised traffic
    do_reset();
    for (int c = 0; c < 400; c++) begin
      src_req_valid = N'($urandom);
      for (int i = 0; i < N; i++) src_req_addr[i*AW +: AW] = AW'($urandom_range(0, 31));
      tick();
    end
    drain(20);
    @(negedge clk);
    chk("final_idle", {56'b0, src_req_ready}, 64'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
